// File: rtl/conv_pkg.sv
// Shared definitions for the multi-channel convolution unit: output modes, FSM states and
// accumulator width helper.
package conv_pkg;

  localparam logic [1:0] MODE_FRESH    = 2'd0;
  localparam logic [1:0] MODE_ADD      = 2'd1;
  localparam logic [1:0] MODE_ADD_RELU = 2'd2;
  localparam logic [1:0] MODE_RELU     = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } convState;

  // Product is 2W bits; summing up to 2^(A+CW) of them needs A+CW guard bits.
  function automatic int unsigned accW(input int unsigned w, input int unsigned a,
                                       input int unsigned cw);
    return 2 * w + a + cw;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One signed MAC lane: accumulates k*n, then shifts, optionally adds the latched partial sum,
// saturates to W bits and optionally clamps negatives to zero into a registered result.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned A    = 7,
  parameter int unsigned CW   = 4,
  parameter int unsigned FRAC = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  input  logic         latchPs,
  input  logic         load,
  input  logic [1:0]   mode,
  input  logic [W-1:0] k,
  input  logic [W-1:0] n,
  input  logic [W-1:0] psIn,
  output logic [W-1:0] result
);

  localparam int unsigned AW = accW(W, A, CW);
  localparam int unsigned SW = AW + 1;
  localparam logic signed [SW-1:0] MaxV = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW-1:0] MinV = {{(SW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  logic signed [AW-1:0]  acc;
  logic signed [W-1:0]   psum;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  accSh;
  logic signed [SW-1:0]  shifted;
  logic signed [SW-1:0]  sum;
  logic        [W-1:0]   sat;
  logic        [W-1:0]   outVal;
  logic                  addEn;
  logic                  reluEn;

  assign addEn  = (mode == MODE_ADD) || (mode == MODE_ADD_RELU);
  assign reluEn = (mode == MODE_ADD_RELU) || (mode == MODE_RELU);

  always_comb begin
    prod    = $signed(k) * $signed(n);
    accSh   = acc >>> FRAC;
    shifted = {{(SW - AW){accSh[AW-1]}}, accSh};
    sum     = shifted;
    if (addEn) begin
      sum = shifted + {{(SW - W){psum[W-1]}}, psum};
    end
    if (sum > MaxV) begin
      sat = {1'b0, {(W - 1){1'b1}}};
    end else if (sum < MinV) begin
      sat = {1'b1, {(W - 1){1'b0}}};
    end else begin
      sat = sum[W-1:0];
    end
    outVal = (reluEn && sat[W-1]) ? '0 : sat;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc    <= '0;
      psum   <= '0;
      result <= '0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + {{(AW - 2 * W){prod[2*W-1]}}, prod};
      end
      if (latchPs) begin
        psum <= psIn;
      end
      if (load) begin
        result <= outVal;
      end
    end
  end

endmodule

// File: rtl/conv_unit_mc.sv
// Multi-channel convolution unit: config/input/output handshakes, beat counting over
// taps x channels, and a bank of 1<<DEPTH MAC lanes feeding the partial-sum chain.
module conv_unit_mc
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 16,
  parameter int unsigned A     = 7,
  parameter int unsigned CW    = 4,
  parameter int unsigned FRAC  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cfgValid,
  output logic                    cfgReady,
  input  logic [A-1:0]            cfgTaps,
  input  logic [CW-1:0]           cfgChannels,
  input  logic [1:0]              cfgMode,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [(W<<DEPTH)-1:0]   kBuffIn,
  input  logic [(W<<DEPTH)-1:0]   nBuffIn,
  input  logic [(W<<DEPTH)-1:0]   partialSumIn,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [(W<<DEPTH)-1:0]   partialSumOut,
  output logic                    busy
);

  localparam int unsigned D    = 1 << DEPTH;
  localparam int unsigned CNTW = A + CW;

  convState          state;
  logic [1:0]        mode;
  logic [CNTW-1:0]   cnt;
  logic [CNTW-1:0]   lastIdx;
  logic [CNTW-1:0]   lastIdxCfg;
  logic [CNTW:0]     tapsN;
  logic [CNTW:0]     chN;
  logic [2*CNTW+1:0] beatsN;
  logic              accept;
  logic              lastBeat;
  logic              clr;
  logic              load;

  assign cfgReady = (state == IDLE);
  assign inReady  = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign accept   = inReady & inValid;
  assign lastBeat = accept && (cnt == lastIdx);
  assign clr      = cfgReady & cfgValid;
  assign load     = (state == OUT) && !outValid;

  // N = 2^CNTW wraps to zero in the low bits, so N-1 still lands on all-ones.
  always_comb begin
    tapsN      = (CNTW + 1)'(cfgTaps) + (CNTW + 1)'(1);
    chN        = (CNTW + 1)'(cfgChannels) + (CNTW + 1)'(1);
    beatsN     = (2 * CNTW + 2)'(tapsN) * (2 * CNTW + 2)'(chN);
    lastIdxCfg = CNTW'(beatsN - (2 * CNTW + 2)'(1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      mode     <= MODE_FRESH;
      cnt      <= '0;
      lastIdx  <= '0;
      outValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfgValid) begin
            mode    <= cfgMode;
            lastIdx <= lastIdxCfg;
            cnt     <= '0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (inValid) begin
            if (cnt == lastIdx) begin
              state <= OUT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (!outValid) begin
            outValid <= 1'b1;
          end else if (outReady) begin
            outValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < D; i++) begin : gLane
    conv_mac_lane #(
      .W   (W),
      .A   (A),
      .CW  (CW),
      .FRAC(FRAC)
    ) uLane (
      .CLK    (CLK),
      .RST    (RST),
      .clr    (clr),
      .en     (accept),
      .latchPs(lastBeat),
      .load   (load),
      .mode   (mode),
      .k      (kBuffIn[W*i +: W]),
      .n      (nBuffIn[W*i +: W]),
      .psIn   (partialSumIn[W*i +: W]),
      .result (partialSumOut[W*i +: W])
    );
  end

endmodule

// File: tb/tb_conv_unit_mc.sv
// Directed self-checking bench for conv_unit_mc (D=4, W=16, FRAC=8).
module tb_conv_unit_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cfgValid;
  logic        cfgReady;
  logic [6:0]  cfgTaps;
  logic [3:0]  cfgChannels;
  logic [1:0]  cfgMode;
  logic        inValid;
  logic        inReady;
  logic [63:0] kBuffIn;
  logic [63:0] nBuffIn;
  logic [63:0] partialSumIn;
  logic        outValid;
  logic        outReady;
  logic [63:0] partialSumOut;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  conv_unit_mc #(
    .DEPTH(2),
    .W    (16),
    .A    (7),
    .CW   (4),
    .FRAC (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .cfgValid     (cfgValid),
    .cfgReady     (cfgReady),
    .cfgTaps      (cfgTaps),
    .cfgChannels  (cfgChannels),
    .cfgMode      (cfgMode),
    .inValid      (inValid),
    .inReady      (inReady),
    .kBuffIn      (kBuffIn),
    .nBuffIn      (nBuffIn),
    .partialSumIn (partialSumIn),
    .outValid     (outValid),
    .outReady     (outReady),
    .partialSumOut(partialSumOut),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic doCfg(input logic [6:0] taps, input logic [3:0] ch, input logic [1:0] md);
    cfgTaps     = taps;
    cfgChannels = ch;
    cfgMode     = md;
    cfgValid    = 1'b1;
    step();
    cfgValid    = 1'b0;
  endtask

  task automatic beat(input logic [63:0] k, input logic [63:0] n, input logic [63:0] ps);
    kBuffIn      = k;
    nBuffIn      = n;
    partialSumIn = ps;
    inValid      = 1'b1;
    step();
    inValid      = 1'b0;
  endtask

  task automatic waitOut(input string tag);
    int i = 0;
    while (!outValid && i < 20) begin
      step();
      i++;
    end
    check({tag, "_outValid"}, 64'(outValid), 64'd1);
  endtask

  task automatic handshake(input string tag, input logic [63:0] exp);
    check({tag, "_data"}, partialSumOut, exp);
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    check({tag, "_validDrop"}, 64'(outValid), 64'd0);
    check({tag, "_cfgReady"}, 64'(cfgReady), 64'd1);
    check({tag, "_dataHeld"}, partialSumOut, exp);
  endtask

  initial begin
    RST          = 1'b1;
    cfgValid     = 1'b0;
    cfgTaps      = '0;
    cfgChannels  = '0;
    cfgMode      = '0;
    inValid      = 1'b0;
    kBuffIn      = '0;
    nBuffIn      = '0;
    partialSumIn = '0;
    outReady     = 1'b0;
    step();
    step();
    check("rst_cfgReady", 64'(cfgReady), 64'd1);
    check("rst_inReady", 64'(inReady), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outValid", 64'(outValid), 64'd0);
    check("rst_data", partialSumOut, 64'd0);
    RST = 1'b0;

    // Single beat, exact one-cycle output latency.
    doCfg(7'd0, 4'd0, 2'd0);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_inReady", 64'(inReady), 64'd1);
    check("t1_cfgReady", 64'(cfgReady), 64'd0);
    beat(rep(16'h0100), rep(16'h0100), rep(16'h0000));
    check("t1_lat0", 64'(outValid), 64'd0);
    step();
    check("t1_lat1", 64'(outValid), 64'd1);
    handshake("t1", rep(16'h0100));

    // 6 beats plus per-lane partial sum sampled only on the last beat; outReady high early.
    doCfg(7'd2, 4'd1, 2'd1);
    outReady = 1'b1;
    for (int i = 0; i < 5; i++) beat(rep(16'h0200), rep(16'h0080), rep(16'hDEAD));
    beat(rep(16'h0200), rep(16'h0080), {16'd8, 16'd7, 16'd6, 16'd5});
    check("t2_earlyReady", 64'(outValid), 64'd0);
    step();
    check("t2_valid", 64'(outValid), 64'd1);
    check("t2_data", partialSumOut, {16'h0608, 16'h0607, 16'h0606, 16'h0605});
    step();
    outReady = 1'b0;
    check("t2_idle", 64'(cfgReady), 64'd1);

    // Positive saturation.
    doCfg(7'd3, 4'd0, 2'd0);
    for (int i = 0; i < 4; i++) beat(rep(16'h7FFF), rep(16'h7FFF), rep(16'h0000));
    waitOut("t3a");
    handshake("t3a", rep(16'h7FFF));

    // Negative saturation, then ReLU on the same case.
    doCfg(7'd1, 4'd1, 2'd0);
    for (int i = 0; i < 4; i++) beat(rep(16'h8000), rep(16'h7FFF), rep(16'h0000));
    waitOut("t3b");
    handshake("t3b", rep(16'h8000));
    doCfg(7'd1, 4'd1, 2'd3);
    for (int i = 0; i < 4; i++) beat(rep(16'h8000), rep(16'h7FFF), rep(16'h0000));
    waitOut("t3c");
    handshake("t3c", rep(16'h0000));

    // Arithmetic shift floors toward minus infinity; lanes differ.
    doCfg(7'd0, 4'd0, 2'd0);
    beat({16'hFFFF, 16'h0180, 16'hFF80, 16'h0001}, rep(16'h0001), rep(16'h0000));
    waitOut("t3d");
    handshake("t3d", {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000});

    // Add then ReLU: negative sums clamp to zero.
    doCfg(7'd0, 4'd0, 2'd2);
    beat(rep(16'h0100), rep(16'h0100), {16'hFE00, 16'h0010, 16'hFF00, 16'h0005});
    waitOut("t3e");
    handshake("t3e", {16'h0000, 16'h0110, 16'h0000, 16'h0105});

    // Backpressure with an ignored config offer, then config during the handshake edge.
    doCfg(7'd0, 4'd0, 2'd0);
    beat(rep(16'h0100), rep(16'h0200), rep(16'h0000));
    waitOut("t4");
    cfgValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_holdValid", 64'(outValid), 64'd1);
      check("t4_holdData", partialSumOut, rep(16'h0200));
      check("t4_holdCfgReady", 64'(cfgReady), 64'd0);
      step();
    end
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    check("t4_idle", 64'(cfgReady), 64'd1);
    check("t4_notTaken", 64'(busy), 64'd0);
    step();
    cfgValid = 1'b0;
    check("t4_taken", 64'(busy), 64'd1);
    beat(rep(16'h0100), rep(16'h0100), rep(16'h0000));
    waitOut("t4b");
    handshake("t4b", rep(16'h0100));

    // inValid gaps with garbage on the bus while stalled.
    doCfg(7'd2, 4'd1, 2'd1);
    for (int i = 0; i < 6; i++) begin
      beat(rep(16'h0200), rep(16'h0080), (i == 5) ? {16'd8, 16'd7, 16'd6, 16'd5} : rep(16'hBEEF));
      kBuffIn = rep(16'h1234);
      nBuffIn = rep(16'h4321);
      partialSumIn = rep(16'h7777);
      step();
      check("t5_busy", 64'(busy), 64'd1);
    end
    waitOut("t5");
    handshake("t5", {16'h0608, 16'h0607, 16'h0606, 16'h0605});

    // Reset mid-transaction discards everything.
    doCfg(7'd2, 4'd1, 2'd0);
    for (int i = 0; i < 3; i++) beat(rep(16'h0100), rep(16'h0100), rep(16'h0000));
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_outValid", 64'(outValid), 64'd0);
    check("t6_cfgReady", 64'(cfgReady), 64'd1);
    check("t6_data", partialSumOut, 64'd0);
    doCfg(7'd0, 4'd0, 2'd0);
    beat(rep(16'h0100), rep(16'h0100), rep(16'h0000));
    waitOut("t6b");
    handshake("t6b", rep(16'h0100));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
